// File: rtl/cronometro_defs.sv
// Shared definitions for the M:SS stopwatch/timer controller: state encoding,
// BCD digit limits and the packed time type.
package cronometro_defs;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    FIM      = 2'd3
  } estado_t;

  localparam logic [3:0] SEG_MAX = 4'd9;
  localparam logic [3:0] DEZ_MAX = 4'd5;
  localparam logic [3:0] MIN_MAX = 4'd9;

  typedef struct packed {
    logic [3:0] min;
    logic [3:0] dez;
    logic [3:0] seg;
  } tempo_t;

  localparam tempo_t TEMPO_ZERO = '{min: 4'd0, dez: 4'd0, seg: 4'd0};
  localparam tempo_t TEMPO_TOPO = '{min: MIN_MAX, dez: DEZ_MAX, seg: SEG_MAX};

  function automatic logic [3:0] satura(input logic [3:0] valor, input logic [3:0] limite);
    return (valor > limite) ? limite : valor;
  endfunction

endpackage

// File: rtl/cronometro_prescaler.sv
// Cycle prescaler for the one-second tick: counts 0..CICLOS_POR_SEG-1 while enabled,
// holds its value otherwise, and flags the last cycle of each second.
module cronometro_prescaler #(
  parameter int unsigned CICLOS_POR_SEG = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned W = (CICLOS_POR_SEG > 2) ? $clog2(CICLOS_POR_SEG) : 1;
  localparam logic [W-1:0] ULTIMO = W'(CICLOS_POR_SEG - 1);

  logic [W-1:0] count_q;

  // Raised on the final cycle regardless of enable; the owner qualifies it.
  assign tick = (count_q == ULTIMO);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= tick ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/cronometro_controle.sv
// Stopwatch/timer sequencing controller: command FSM plus BCD M:SS digit stepping,
// advanced once per prescaler tick while counting.
module cronometro_controle
  import cronometro_defs::*;
#(
  parameter int unsigned CICLOS_POR_SEG = 50000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Iniciar,
  input  logic       Pausar,
  input  logic       Zerar,
  input  logic       Carregar,
  input  logic       Modo,
  input  logic [3:0] CargaMin,
  input  logic [3:0] CargaDez,
  input  logic [3:0] CargaSeg,
  output logic [3:0] Minutos,
  output logic [3:0] DezenaSeg,
  output logic [3:0] Segundos,
  output logic       Contando,
  output logic       Fim
);

  estado_t state_q, state_d;
  tempo_t  tempo_q, tempo_d;
  logic    desce_q, desce_d;
  tempo_t  proximo;
  logic    presc_clear, presc_en, tick;

  cronometro_prescaler #(
    .CICLOS_POR_SEG(CICLOS_POR_SEG)
  ) u_prescaler (
    .clk   (Clock),
    .rst   (Reset),
    .clear (presc_clear),
    .enable(presc_en),
    .tick  (tick)
  );

  // One-second step in the latched direction; 0:00 down is unreachable (FIM stops it).
  always_comb begin
    proximo = tempo_q;
    if (!desce_q) begin
      if (tempo_q.seg == SEG_MAX) begin
        proximo.seg = 4'd0;
        if (tempo_q.dez == DEZ_MAX) begin
          proximo.dez = 4'd0;
          proximo.min = tempo_q.min + 4'd1;
        end else begin
          proximo.dez = tempo_q.dez + 4'd1;
        end
      end else begin
        proximo.seg = tempo_q.seg + 4'd1;
      end
    end else begin
      if (tempo_q.seg == 4'd0) begin
        proximo.seg = SEG_MAX;
        if (tempo_q.dez == 4'd0) begin
          proximo.dez = DEZ_MAX;
          proximo.min = tempo_q.min - 4'd1;
        end else begin
          proximo.dez = tempo_q.dez - 4'd1;
        end
      end else begin
        proximo.seg = tempo_q.seg - 4'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    tempo_d     = tempo_q;
    desce_d     = desce_q;
    presc_clear = 1'b0;
    presc_en    = 1'b0;
    if (Zerar) begin
      tempo_d     = TEMPO_ZERO;
      presc_clear = 1'b1;
      state_d     = PARADO;
    end else if (Carregar) begin
      tempo_d.min = satura(CargaMin, MIN_MAX);
      tempo_d.dez = satura(CargaDez, DEZ_MAX);
      tempo_d.seg = satura(CargaSeg, SEG_MAX);
      presc_clear = 1'b1;
      state_d     = PARADO;
    end else begin
      unique case (state_q)
        PARADO: begin
          if (Iniciar) begin
            desce_d     = Modo;
            presc_clear = 1'b1;
            if ((Modo && tempo_q == TEMPO_ZERO) || (!Modo && tempo_q == TEMPO_TOPO)) begin
              state_d = FIM;
            end else begin
              state_d = CONTANDO;
            end
          end
        end
        CONTANDO: begin
          if (Pausar) begin
            state_d = PAUSADO;
          end else begin
            presc_en = 1'b1;
            if (tick) begin
              tempo_d = proximo;
              if (proximo == (desce_q ? TEMPO_ZERO : TEMPO_TOPO)) state_d = FIM;
            end
          end
        end
        PAUSADO: begin
          if (Iniciar && !Pausar) state_d = CONTANDO;
        end
        FIM: begin
        end
        default: state_d = PARADO;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= PARADO;
      tempo_q <= TEMPO_ZERO;
      desce_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tempo_q <= tempo_d;
      desce_q <= desce_d;
    end
  end

  assign Minutos   = tempo_q.min;
  assign DezenaSeg = tempo_q.dez;
  assign Segundos  = tempo_q.seg;
  assign Contando  = (state_q == CONTANDO);
  assign Fim       = (state_q == FIM);

endmodule

// File: tb/tb_cronometro_controle.sv
// Self-checking bench for cronometro_controle: a seconds-based reference model checked
// every cycle, plus directed scenarios with hand-computed digit expectations.
module tb_cronometro_controle;

  localparam int N = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Iniciar = 1'b0, Pausar = 1'b0, Zerar = 1'b0, Carregar = 1'b0, Modo = 1'b0;
  logic [3:0] CargaMin = 4'd0, CargaDez = 4'd0, CargaSeg = 4'd0;
  logic [3:0] Minutos, DezenaSeg, Segundos;
  logic       Contando, Fim;

  cronometro_controle #(
    .CICLOS_POR_SEG(N)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Iniciar  (Iniciar),
    .Pausar   (Pausar),
    .Zerar    (Zerar),
    .Carregar (Carregar),
    .Modo     (Modo),
    .CargaMin (CargaMin),
    .CargaDez (CargaDez),
    .CargaSeg (CargaSeg),
    .Minutos  (Minutos),
    .DezenaSeg(DezenaSeg),
    .Segundos (Segundos),
    .Contando (Contando),
    .Fim      (Fim)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nome, input int atual, input int esperado);
    checks++;
    if (atual != esperado) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  // Reference model: time as whole seconds 0..599 plus elapsed cycles of the current second.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_END = 3;
  int m_st = M_IDLE, m_secs = 0, m_frac = 0;
  bit m_down = 1'b0, m_valid = 1'b0;

  function automatic int lim(input int v, input int l);
    return (v > l) ? l : v;
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      m_st = M_IDLE; m_secs = 0; m_frac = 0; m_down = 1'b0; m_valid = 1'b1;
    end else if (Zerar) begin
      m_st = M_IDLE; m_secs = 0; m_frac = 0;
    end else if (Carregar) begin
      m_st   = M_IDLE;
      m_frac = 0;
      m_secs = lim(int'(CargaMin), 9) * 60 + lim(int'(CargaDez), 5) * 10 + lim(int'(CargaSeg), 9);
    end else if (m_st == M_IDLE) begin
      if (Iniciar) begin
        m_down = Modo;
        m_frac = 0;
        m_st   = ((Modo && m_secs == 0) || (!Modo && m_secs == 599)) ? M_END : M_RUN;
      end
    end else if (m_st == M_RUN) begin
      if (Pausar) m_st = M_PAUSE;
      else if (m_frac == N - 1) begin
        m_frac = 0;
        m_secs = m_down ? m_secs - 1 : m_secs + 1;
        if (m_secs == (m_down ? 0 : 599)) m_st = M_END;
      end else m_frac = m_frac + 1;
    end else if (m_st == M_PAUSE) begin
      if (Iniciar && !Pausar) m_st = M_RUN;
    end
  end

  always @(negedge Clock) begin
    if (m_valid) begin
      chk("model.Minutos", int'(Minutos), m_secs / 60);
      chk("model.DezenaSeg", int'(DezenaSeg), (m_secs % 60) / 10);
      chk("model.Segundos", int'(Segundos), m_secs % 10);
      chk("model.Contando", int'(Contando), int'(m_st == M_RUN));
      chk("model.Fim", int'(Fim), int'(m_st == M_END));
    end
  end

  task automatic ciclos(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic ver(input string tag, input int m, input int d, input int s,
                     input int cont, input int fim);
    chk({tag, ".min"}, int'(Minutos), m);
    chk({tag, ".dez"}, int'(DezenaSeg), d);
    chk({tag, ".seg"}, int'(Segundos), s);
    chk({tag, ".contando"}, int'(Contando), cont);
    chk({tag, ".fim"}, int'(Fim), fim);
  endtask

  task automatic carrega(input int m, input int d, input int s);
    CargaMin = 4'(m); CargaDez = 4'(d); CargaSeg = 4'(s);
    Carregar = 1'b1;
    ciclos(1);
    Carregar = 1'b0;
  endtask

  task automatic inicia(input logic modo);
    Modo = modo;
    Iniciar = 1'b1;
    ciclos(1);
    Iniciar = 1'b0;
  endtask

  initial begin
    ciclos(2);
    ver("reset", 0, 0, 0, 0, 0);
    Reset = 1'b0;

    // Count up from 0:00
    inicia(1'b0);
    ver("up.start", 0, 0, 0, 1, 0);
    ciclos(3);
    ver("up.before_tick", 0, 0, 0, 1, 0);
    ciclos(1);
    ver("up.t4", 0, 0, 1, 1, 0);
    ciclos(36);
    ver("up.t40", 0, 1, 0, 1, 0);
    ciclos(199);
    ver("up.t239", 0, 5, 9, 1, 0);
    ciclos(1);
    ver("up.t240", 1, 0, 0, 1, 0);

    // Count down from 0:05 to the end
    carrega(0, 0, 5);
    ver("down.load", 0, 0, 5, 0, 0);
    inicia(1'b1);
    ciclos(19);
    ver("down.t19", 0, 0, 1, 1, 0);
    ciclos(1);
    ver("down.t20", 0, 0, 0, 0, 1);
    inicia(1'b1);
    ciclos(2);
    ver("down.fim_hold", 0, 0, 0, 0, 1);

    // Saturation at 9:59
    carrega(9, 5, 8);
    inicia(1'b0);
    ciclos(3);
    ver("sat.t3", 9, 5, 8, 1, 0);
    ciclos(1);
    ver("sat.t4", 9, 5, 9, 0, 1);
    ciclos(20);
    ver("sat.hold", 9, 5, 9, 0, 1);

    // Pause two cycles after a tick preserves the fractional second
    carrega(0, 0, 0);
    inicia(1'b0);
    ciclos(4);
    ver("pause.tick", 0, 0, 1, 1, 0);
    ciclos(2);
    Pausar = 1'b1;
    ciclos(1);
    Pausar = 1'b0;
    ver("pause.enter", 0, 0, 1, 0, 0);
    ciclos(10);
    ver("pause.held", 0, 0, 1, 0, 0);
    inicia(1'b0);
    ver("pause.resume", 0, 0, 1, 1, 0);
    ciclos(1);
    ver("pause.r1", 0, 0, 1, 1, 0);
    ciclos(1);
    ver("pause.r2", 0, 0, 2, 1, 0);
    Pausar = 1'b1;
    ciclos(1);
    Iniciar = 1'b1;
    ciclos(1);
    Pausar = 1'b0;
    Iniciar = 1'b0;
    ver("pause.both_paused", 0, 0, 2, 0, 0);
    inicia(1'b0);
    Iniciar = 1'b1;
    Pausar  = 1'b1;
    ciclos(1);
    Iniciar = 1'b0;
    Pausar  = 1'b0;
    ver("pause.both_running", 0, 0, 2, 0, 0);

    // Load clamping
    carrega(12, 7, 11);
    ver("clamp", 9, 5, 9, 0, 0);

    // Pausar on the tick cycle discards the step
    carrega(0, 0, 0);
    inicia(1'b0);
    ciclos(3);
    Pausar = 1'b1;
    ciclos(1);
    Pausar = 1'b0;
    ver("tick_pause", 0, 0, 0, 0, 0);
    inicia(1'b0);
    ciclos(1);
    ver("tick_pause.resume", 0, 0, 1, 1, 0);

    // Zerar on the tick cycle
    ciclos(3);
    Zerar = 1'b1;
    ciclos(1);
    Zerar = 1'b0;
    ver("tick_zerar", 0, 0, 0, 0, 0);
    ciclos(4);
    ver("tick_zerar.idle", 0, 0, 0, 0, 0);

    // Reset beats Carregar mid-count
    inicia(1'b0);
    ciclos(5);
    ver("rst.running", 0, 0, 1, 1, 0);
    CargaMin = 4'd3; CargaDez = 4'd2; CargaSeg = 4'd1;
    Reset = 1'b1;
    Carregar = 1'b1;
    ciclos(1);
    Reset = 1'b0;
    Carregar = 1'b0;
    ver("rst.carregar", 0, 0, 0, 0, 0);
    ciclos(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
